sn76489_bus_writer: RTL and testbench
=====================================

// Module: sn76489_bus_writer
// PURPOSE
//   Host-side driver for the SN76489 PSG register interface: the writer end of the bus the PSG core decodes.
//   Takes one register-write request per valid/ready handshake (channel, tone-or-volume, value).
//   Encodes it into SN76489 latch byte (+ data byte for 10-bit tone) and strobes each byte onto psg_data/psg_we.
//   Enforces a minimum strobe-to-strobe spacing so the PSG never sees back-to-back writes.
// PARAMETERS
//   GAP_CYCLES  32  min clk cycles between consecutive psg_we pulses; legal range >= 2
// PORTS
//   clk        in   1   single clock, all logic rising-edge
//   reset      in   1   synchronous, active-high
//   req_valid  in   1   request present
//   req_ready  out  1   request accepted on cycle where valid&&ready
//   req_chan   in   2   channel 0-2 tone, 3 noise
//   req_vol    in   1   1 = attenuation write, 0 = tone/noise-control write
//   req_value  in   10  tone divider [9:0]; attenuation uses [3:0]; noise uses [2:0] (FB,NF1,NF0)
//   psg_data   out  8   byte presented to PSG, registered, held between strobes
//   psg_we     out  1   1-cycle active-high write strobe, psg_data valid same cycle
//   busy       out  1   high from acceptance until req_ready returns
// BEHAVIOUR
//   Reset: psg_data=8'h00, psg_we=0, busy=0, req_ready=0 while reset high, FSM->IDLE, pending byte discarded.
//   Latch byte = {1'b1, chan[1:0], vol, low4}; low4 = value[3:0] (tone/vol), {1'b0,value[2:0]} (noise ctl).
//   Data byte = {2'b00, value[9:4]}; emitted only when !vol && chan!=3.
//   Fields captured at acceptance; may change freely while not accepted.
//   FSM: IDLE -> LATCH -> GAP1 -> [DATA -> GAP2] -> IDLE. req_ready = (state==IDLE) && !reset.
//   Accept at cycle N: latch strobe at N+1; data strobe (if any) at N+1+GAP_CYCLES.
//   GAP counts GAP_CYCLES-1 cycles; req_ready high again at N+GAP_CYCLES (1 byte) / N+2*GAP_CYCLES (2 bytes).
//   So strobe spacing is exactly GAP_CYCLES when requests are back-to-back, never less.
//   psg_we only in LATCH/DATA states, never two consecutive cycles; psg_data changes only with psg_we.
//   Reset mid-GAP or mid-DATA: next cycle psg_we=0, IDLE, no further strobe for the aborted request.
//   Counter width $clog2(GAP_CYCLES); no wrap - loaded at strobe, counts down to 0.
// CONFIGURATION
//   SN76489_WR_DEDUP_EN defined: shadow copy per chan of tone[9:0]/noise[2:0] and atten[3:0], valid bits.
//     Shadow valid bits cleared by reset; written at acceptance of every request that strobes.
//     Request equal to a valid shadow entry (masked to used bits) accepted with no strobe.
//     FSM stays IDLE, req_ready stays high, busy stays 0.
//   Undefined: no shadow state; every accepted request produces its strobe(s).
// STRUCTURE
//   sn76489_pkg: state enum (IDLE,LATCH,GAP1,DATA,GAP2), latch-bit/field constants.
//   sn76489_pkg also holds pure functions encode_latch(chan,vol,value) and needs_data(chan,vol).
//   Sub-module sn76489_gap_timer: load-on-strobe down-counter with done flag, parameterised GAP_CYCLES.
// TESTING
//   T1 chan0 tone 10'h3FE -> psg_we at N+1 data 8'h8E, at N+33 data 8'h3F; ready at N+64.
//   T2 chan2 vol 4'h5 -> single strobe 8'hD5 at N+1; ready at N+32; no 2nd strobe.
//   T3 chan3 noise 3'b100 (value 10'h3F4) -> single strobe 8'hE4; upper bits ignored.
//   T4 valid held continuously, 3 mixed requests -> psg_we spacing exactly 32, bytes in order, no loss.
//   T5 reset asserted in GAP1 of chan1 tone 10'h155 -> 8'hA5 seen, 8'h15 never seen; ready 1 cycle after reset drops.
//   T6 (DEDUP_EN) chan2 vol 5 twice -> one strobe 8'hD5; 2nd accepted with busy=0; after reset both strobe.

Source files
------------

// File: rtl/sn76489_pkg.sv
// Shared types and byte-encoding helpers for the SN76489 register-bus writer.
// Optional write de-duplication is enabled by defining SN76489_WR_DEDUP_EN.
package sn76489_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    GAP1  = 3'd2,
    DATA  = 3'd3,
    GAP2  = 3'd4
  } state_t;

  localparam logic [7:0] LATCH_BIT  = 8'h80;
  localparam logic [1:0] NOISE_CHAN = 2'd3;

  // Noise control only defines FB,NF1,NF0; bit 3 of the latch nibble is forced low.
  function automatic logic [7:0] encode_latch(input logic [1:0] chan, input logic vol,
                                              input logic [9:0] value);
    logic [3:0] low4;
    low4 = (!vol && chan == NOISE_CHAN) ? {1'b0, value[2:0]} : value[3:0];
    return LATCH_BIT | {1'b0, chan, vol, low4};
  endfunction

  function automatic logic needs_data(input logic [1:0] chan, input logic vol);
    return !vol && (chan != NOISE_CHAN);
  endfunction

  function automatic logic [7:0] encode_data(input logic [9:0] value);
    return {2'b00, value[9:4]};
  endfunction

endpackage

// File: rtl/sn76489_gap_timer.sv
// Load-on-strobe down-counter; done marks the last cycle of the current gap.
module sn76489_gap_timer #(
  parameter int GAP_CYCLES = 32,
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt <= CW'(1));

endmodule

// File: rtl/sn76489_bus_writer.sv
// SN76489 register-bus writer: encodes requests into latch/data bytes with strobe spacing.
// Define SN76489_WR_DEDUP_EN to suppress writes that repeat the last value per register.
module sn76489_bus_writer
  import sn76489_pkg::*;
#(
  parameter int GAP_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_chan,
  input  logic       req_vol,
  input  logic [9:0] req_value,
  output logic [7:0] psg_data,
  output logic       psg_we,
  output logic       busy
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // A gap before a data byte lasts one cycle longer than a gap before IDLE,
  // because the next latch strobe lands one cycle after acceptance.
  localparam logic [CW-1:0] GAP_FULL  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_SHORT = CW'(GAP_CYCLES - 2);
  localparam bit SKIP_SHORT = (GAP_CYCLES == 2);

  state_t          state_q, state_d;
  logic [7:0]      data_byte_p1;
  logic            has_data_p1;
  logic            accept, dup_hit;
  logic            tmr_load, tmr_done;
  logic [CW-1:0]   tmr_val;

  assign req_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE) && !reset;
  assign accept    = req_valid && req_ready;

`ifdef SN76489_WR_DEDUP_EN
  logic [9:0] tone_sh  [4];
  logic [3:0] atten_sh [4];
  logic [3:0] tone_vld, atten_vld;

  always_comb begin
    dup_hit = 1'b0;
    if (req_vol)
      dup_hit = atten_vld[req_chan] && (atten_sh[req_chan] == req_value[3:0]);
    else if (req_chan == NOISE_CHAN)
      dup_hit = tone_vld[req_chan] && (tone_sh[req_chan][2:0] == req_value[2:0]);
    else
      dup_hit = tone_vld[req_chan] && (tone_sh[req_chan] == req_value);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tone_vld  <= '0;
      atten_vld <= '0;
    end else if (accept && !dup_hit) begin
      if (req_vol) atten_vld[req_chan] <= 1'b1;
      else         tone_vld[req_chan]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !dup_hit) begin
      if (req_vol) atten_sh[req_chan] <= req_value[3:0];
      else         tone_sh[req_chan]  <= req_value;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  sn76489_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = GAP_SHORT;
    case (state_q)
      IDLE: if (accept && !dup_hit) state_d = LATCH;
      LATCH: begin
        tmr_load = 1'b1;
        if (has_data_p1) begin
          tmr_val = GAP_FULL;
          state_d = GAP1;
        end else begin
          state_d = SKIP_SHORT ? IDLE : GAP1;
        end
      end
      GAP1: if (tmr_done) state_d = has_data_p1 ? DATA : IDLE;
      DATA: begin
        tmr_load = 1'b1;
        state_d  = SKIP_SHORT ? IDLE : GAP2;
      end
      GAP2: if (tmr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      psg_we   <= 1'b0;
      psg_data <= 8'h00;
    end else begin
      state_q <= state_d;
      psg_we  <= (state_d == LATCH) || (state_d == DATA);
      if (state_q == IDLE && state_d == LATCH)
        psg_data <= encode_latch(req_chan, req_vol, req_value);
      else if (state_d == DATA)
        psg_data <= data_byte_p1;
    end
  end

  // Request capture: fields are free to change once the handshake completes.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_byte_p1 <= encode_data(req_value);
      has_data_p1  <= needs_data(req_chan, req_vol);
    end
  end

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// Bench for sn76489_bus_writer: directed cases plus randomized traffic against a cycle-scheduled model.
module tb_sn76489_bus_writer;

  localparam int G = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_chan = 2'd0;
  logic       req_vol = 1'b0;
  logic [9:0] req_value = 10'd0;
  logic [7:0] psg_data;
  logic       psg_we;
  logic       busy;

  sn76489_bus_writer #(.GAP_CYCLES(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_chan  (req_chan),
    .req_vol   (req_vol),
    .req_value (req_value),
    .psg_data  (psg_data),
    .psg_we    (psg_we),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] b; } ev_t;

  ev_t        q[$];
  int         we_log[$];
  logic [7:0] we_bytes[$];
  int         cyc, n_cmp, n_bad, ready_at, zero_at, n0;
  logic [7:0] cur_data;
  bit         acc;
  bit         tone_v[4], att_v[4];
  int         tone_s[4], att_s[4];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_latch(input int ch, input int vl, input int val);
    int low;
    low = (vl != 0 || ch != 3) ? (val % 16) : (val % 8);
    return 8'(128 + ch * 32 + vl * 16 + low);
  endfunction

  function automatic bit is_dup(input int ch, input int vl, input int val);
`ifdef SN76489_WR_DEDUP_EN
    if (vl != 0) return att_v[ch] && (att_s[ch] == val % 16);
    if (ch == 3) return tone_v[3] && (tone_s[3] % 8 == val % 8);
    return tone_v[ch] && (tone_s[ch] == val);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs against the schedule, advance the model.
  task automatic step(input logic v, input logic [1:0] ch, input logic vl,
                      input logic [9:0] val, input logic r);
    logic we_exp, rdy_exp, busy_exp;
    @(negedge clk);
    reset = r; req_valid = v; req_chan = ch; req_vol = vl; req_value = val;
    #1;
    if (cyc == zero_at) cur_data = 8'h00;
    we_exp = 1'b0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      we_exp   = 1'b1;
      cur_data = q[0].b;
      void'(q.pop_front());
    end
    rdy_exp  = !r && (cyc >= ready_at);
    busy_exp = !r && (cyc < ready_at);
    check("psg_we", 32'(psg_we), 32'(we_exp));
    check("psg_data", 32'(psg_data), 32'(cur_data));
    check("req_ready", 32'(req_ready), 32'(rdy_exp));
    check("busy", 32'(busy), 32'(busy_exp));
    if (psg_we === 1'b1) begin
      we_log.push_back(cyc);
      we_bytes.push_back(psg_data);
    end
    acc = 1'b0;
    if (r) begin
      q.delete();
      ready_at = cyc + 1;
      zero_at  = cyc + 1;
      for (int i = 0; i < 4; i++) begin tone_v[i] = 1'b0; att_v[i] = 1'b0; end
    end else if (v && rdy_exp) begin
      acc = 1'b1;
      if (!is_dup(int'(ch), int'(vl), int'(val))) begin
        q.push_back('{cyc + 1, ref_latch(int'(ch), int'(vl), int'(val))});
        if (vl == 1'b0 && ch != 2'd3) begin
          q.push_back('{cyc + 1 + G, 8'(int'(val) / 16)});
          ready_at = cyc + 2 * G;
        end else begin
          ready_at = cyc + G;
        end
        if (vl) begin att_v[ch] = 1'b1; att_s[ch] = int'(val); end
        else    begin tone_v[ch] = 1'b1; tone_s[ch] = int'(val); end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 10'd0, 1'b0);
  endtask

  // Hold valid with the given fields until the model sees the handshake.
  task automatic push_req(input logic [1:0] ch, input logic vl, input logic [9:0] val);
    int k;
    k = 0;
    do begin
      step(1'b1, ch, vl, val, 1'b0);
      k++;
    end while (!acc && k < 200);
    check("accept_timeout", 32'(acc), 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; ready_at = 0; zero_at = -1; cur_data = 8'h00;
    repeat (3) @(posedge clk);
    step(1'b0, 2'd0, 1'b0, 10'd0, 1'b1);
    idle(2);

    // T1: two-byte tone write
    n0 = cyc;
    push_req(2'd0, 1'b0, 10'h3FE);
    idle(1);
    check("t1_latch", 32'(psg_data), 32'h8E);
    idle(32);
    check("t1_data", 32'(psg_data), 32'h3F);
    idle(31);
    check("t1_ready", 32'(req_ready), 32'd1);

    // T2: attenuation, single byte
    push_req(2'd2, 1'b1, 10'h005);
    idle(1);
    check("t2_latch", 32'(psg_data), 32'hD5);
    idle(31);
    check("t2_ready", 32'(req_ready), 32'd1);

    // T3: noise control, upper value bits ignored
    push_req(2'd3, 1'b0, 10'h3F4);
    idle(1);
    check("t3_latch", 32'(psg_data), 32'hE4);
    idle(40);

    // T4: back-to-back requests with valid held high
    we_log.delete(); we_bytes.delete();
    push_req(2'd1, 1'b0, 10'h2A7);
    push_req(2'd0, 1'b1, 10'h003);
    push_req(2'd3, 1'b0, 10'h002);
    idle(80);
    check("t4_count", 32'(we_log.size()), 32'd4);
    if (we_log.size() == 4) begin
      for (int i = 1; i < 4; i++) check("t4_spacing", 32'(we_log[i] - we_log[i-1]), 32'(G));
      check("t4_b0", 32'(we_bytes[0]), 32'hA7);
      check("t4_b1", 32'(we_bytes[1]), 32'h2A);
      check("t4_b2", 32'(we_bytes[2]), 32'h93);
      check("t4_b3", 32'(we_bytes[3]), 32'hE2);
    end

    // T5: reset while waiting in the first gap
    push_req(2'd1, 1'b0, 10'h155);
    idle(1);
    check("t5_latch", 32'(psg_data), 32'hA5);
    idle(8);
    step(1'b0, 2'd0, 1'b0, 10'd0, 1'b1);
    we_log.delete(); we_bytes.delete();
    idle(1);
    check("t5_ready", 32'(req_ready), 32'd1);
    idle(60);
    check("t5_no_data", 32'(we_log.size()), 32'd0);

`ifdef SN76489_WR_DEDUP_EN
    // T6: repeated attenuation write is swallowed until reset
    we_log.delete();
    push_req(2'd2, 1'b1, 10'h005);
    idle(40);
    push_req(2'd2, 1'b1, 10'h005);
    idle(1);
    check("t6_busy", 32'(busy), 32'd0);
    idle(40);
    check("t6_one_strobe", 32'(we_log.size()), 32'd1);
    step(1'b0, 2'd0, 1'b0, 10'd0, 1'b1);
    we_log.delete();
    push_req(2'd2, 1'b1, 10'h005);
    idle(40);
    push_req(2'd2, 1'b1, 10'h005);
    idle(40);
    check("t6_two_strobes", 32'(we_log.size()), 32'd2);
`endif

    // Randomized traffic, with a bias toward repeated values and occasional resets
    for (int i = 0; i < 5000; i++) begin
      logic [9:0] val;
      val = ($urandom_range(0, 1) != 0) ? 10'($urandom) : 10'h003;
      step(($urandom_range(0, 9) < 7), 2'($urandom), 1'($urandom), val,
           ($urandom_range(0, 299) == 0));
    end
    idle(2 * G + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
